// File: rtl/muldiv_pkg.sv
// Op encoding, FSM states and op-class helpers shared by the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Even encodings are the signed variants.
  function automatic logic is_signed(input muldiv_op_e op);
    logic [2:0] v;
    v = op;
    return ~v[0];
  endfunction

  function automatic logic is_acc(input muldiv_op_e op);
    logic [2:0] v;
    v = op;
    return v[2];
  endfunction

  function automatic logic is_sub(input muldiv_op_e op);
    logic [2:0] v;
    v = op;
    return v[2] & v[1];
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract if it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, div_i};
  // The partial remainder stays below the divisor, so the top bit of diff is a clean borrow.
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative signed/unsigned multiply/divide unit feeding HI/LO over a start/ready handshake.
// Define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int MUL_ITER = WIDTH / MUL_BITS;
  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam int SUM_W    = WIDTH + MUL_BITS;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  muldiv_state_e         state_q, state_d;
  muldiv_op_e            op;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*WIDTH-1:0]    p_q, p_d, prod, res;
  logic [WIDTH-1:0]      m_q, mag_a, mag_b, rem_next;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic                  is_div_q, sign_a_q, neg_q, dz_q;
  logic                  legal, accept, calc_last, sign_a, sign_b, q_bit;
  logic [SUM_W-1:0]      mul_sum;

  assign op     = muldiv_op_e'(op_i);
  assign a_s    = a_i;
  assign b_s    = b_i;
  assign sign_a = is_signed(op) && (a_s < 0);
  assign sign_b = is_signed(op) && (b_s < 0);
  assign mag_a  = neg_if(a_i, sign_a);
  assign mag_b  = neg_if(b_i, sign_b);

`ifdef MULDIV_MADD_EN
  assign legal = 1'b1;
`else
  assign legal = ~is_acc(op);
`endif

  assign accept    = start_i && !flush_i && legal &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign calc_last = (cnt_q == (is_div_q ? CNT_W'(WIDTH - 1) : CNT_W'(MUL_ITER - 1)));

  always_comb begin
    state_d = state_q;
    busy_o  = (state_q == ST_CALC) || (state_q == ST_FIX);
    ready_o = (state_q == ST_DONE);
    unique case (state_q)
      ST_IDLE, ST_DONE: state_d = ST_IDLE;
      ST_CALC:          if (calc_last) state_d = ST_FIX;
      ST_FIX:           state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
    if (accept) state_d = (is_div(op) && (b_i == '0)) ? ST_FIX : ST_CALC;
    if (flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cnt_q <= '0;
      else if (state_q == ST_CALC) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Iteration stage: p_q is {partial, multiplier} for multiply and {remainder, quotient} for divide.
  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (p_q[2*WIDTH-1:WIDTH]),
    .bit_i (p_q[WIDTH-1]),
    .div_i (m_q),
    .rem_o (rem_next),
    .q_o   (q_bit)
  );

  assign mul_sum = SUM_W'(p_q[2*WIDTH-1:WIDTH]) + SUM_W'(m_q) * SUM_W'(p_q[MUL_BITS-1:0]);
  assign p_d     = is_div_q ? {rem_next, p_q[WIDTH-2:0], q_bit}
                            : {mul_sum, p_q[WIDTH-1:MUL_BITS]};

  always_ff @(posedge clk) begin
    if (accept) begin
      p_q      <= {{WIDTH{1'b0}}, is_div(op) ? mag_a : mag_b};
      m_q      <= is_div(op) ? mag_b : mag_a;
      is_div_q <= is_div(op);
      sign_a_q <= sign_a;
      neg_q    <= sign_a ^ sign_b;
      dz_q     <= is_div(op) && (b_i == '0);
    end else if (state_q == ST_CALC) begin
      p_q <= p_d;
    end
  end

`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] acc_q;
  logic               acc_op_q, sub_op_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q    <= {hi_i, lo_i};
      acc_op_q <= is_acc(op);
      sub_op_q <= is_sub(op);
    end
  end
`else
  logic unused_acc;
  assign unused_acc = ^{hi_i, lo_i};
`endif

  // Fix stage: sign correction, divide-by-zero result and optional accumulate.
  always_comb begin
    prod = neg2_if(p_q, neg_q);
    res  = prod;
    if (dz_q)
      res = {neg_if(p_q[WIDTH-1:0], sign_a_q), {WIDTH{1'b1}}};
    else if (is_div_q)
      res = {neg_if(p_q[2*WIDTH-1:WIDTH], sign_a_q), neg_if(p_q[WIDTH-1:0], neg_q)};
`ifdef MULDIV_MADD_EN
    else if (acc_op_q)
      res = sub_op_q ? (acc_q - prod) : (acc_q + prod);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else if ((state_q == ST_FIX) && !flush_i) begin
      hi_o       <= res[2*WIDTH-1:WIDTH];
      lo_o       <= res[WIDTH-1:0];
      div_zero_o <= dz_q;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: the driver queues model results, a monitor checks each ready_o.
module tb_hilo_muldiv #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
);

  localparam int W = WIDTH;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic [31:0]  t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i, flush_i;
  logic [2:0]   op_i;
  logic [W-1:0] a_i, b_i, hi_i, lo_i;
  logic         busy_o, ready_o, div_zero_o;
  logic [W-1:0] hi_o, lo_o;

  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  exp_t         sb_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         last_dz = 1'b0;
  logic [W-1:0] imin;
  logic [2:0]   rop;
  int           t0;

  hilo_muldiv #(.WIDTH(WIDTH), .MUL_BITS(MUL_BITS)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .hi_i(hi_i), .lo_i(lo_i), .flush_i(flush_i), .busy_o(busy_o), .ready_o(ready_o),
    .hi_o(hi_o), .lo_o(lo_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic straight from the op definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b, hi, lo,
                                 input int start_cyc);
    exp_t e;
    logic [2*W-1:0] p, r;
    logic signed [W-1:0] sa, sb, sq, sr;
    logic [W-1:0] min_v;
    min_v = {1'b1, {(W-1){1'b0}}};
    sa = a;
    sb = b;
    e.dz = 1'b0;
    if (op[0]) p = a * b;
    else       p = sa * sb;
    case (op)
      3'd2, 3'd3: begin
        if (b == '0) begin
          e.dz = 1'b1;
          r = {a, {W{1'b1}}};
        end else if (op == 3'd2 && a == min_v && b == '1) begin
          r = {{W{1'b0}}, min_v};
        end else if (op == 3'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          r = {sr, sq};
        end else begin
          r = {a % b, a / b};
        end
      end
      3'd4, 3'd5: r = {hi, lo} + p;
      3'd6, 3'd7: r = {hi, lo} - p;
      default:    r = p;
    endcase
    e.hi = r[2*W-1:W];
    e.lo = r[W-1:0];
    if (e.dz)                      e.t = 32'(start_cyc + 2);
    else if (op == 3'd2 || op == 3'd3) e.t = 32'(start_cyc + W + 2);
    else                           e.t = 32'(start_cyc + W / MUL_BITS + 2);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return {1'b1, {(W-1){1'b0}}};
      4:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Called just after a rising edge; holds start_i for exactly one cycle.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b, hi, lo, input bit expect_it);
    op_i = op; a_i = a; b_i = b; hi_i = hi; lo_i = lo; start_i = 1'b1;
    if (expect_it) sb_q.push_back(model(op, a, b, hi, lo, cyc));
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout pending %0d want 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!ready_o) begin
      errors++;
      $display("FAIL ready_timeout got 0 want 1");
      sb_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst && ready_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready got 1 want 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("ready_cycle", 64'(cyc), 64'(mon_e.t));
        check("hi_o", 64'(hi_o), 64'(mon_e.hi));
        check("lo_o", 64'(lo_o), 64'(mon_e.lo));
        check("div_zero_o", 64'(div_zero_o), 64'(mon_e.dz));
        check("busy_at_ready", 64'(busy_o), 64'd0);
        last_hi = mon_e.hi;
        last_lo = mon_e.lo;
        last_dz = mon_e.dz;
      end
    end
  end

  initial begin
    imin = {1'b1, {(W-1){1'b0}}};
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
    a_i = '0; b_i = '0; hi_i = '0; lo_i = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_dz", 64'(div_zero_o), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, W'(-3), W'(7), '0, '0, 1'b1);     wait_done();
    issue(3'd2, W'(-7), W'(2), '0, '0, 1'b1);     wait_done();
    issue(3'd3, imin, '1, '0, '0, 1'b1);          wait_done();
    issue(3'd2, W'(5), '0, '0, '0, 1'b1);         wait_done();
    issue(3'd2, W'(-5), '0, '0, '0, 1'b1);        wait_done();
    issue(3'd2, imin, '1, '0, '0, 1'b1);          wait_done();

    // Back-to-back: second request lands in the first one's DONE cycle.
    issue(3'd1, '1, '1, '0, '0, 1'b1);
    wait_ready();
    issue(3'd0, W'(12345), W'(-77), '0, '0, 1'b1);
    wait_done();

    // Flush mid-divide; a start while busy is ignored.
    issue(3'd3, W'($urandom), W'($urandom) | W'(1), '0, '0, 1'b0);
    t0 = cyc - 1;
    while (cyc < t0 + 5) begin @(posedge clk); #1; end
    op_i = 3'd0; a_i = W'(9); b_i = W'(9); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    check("flush_busy_c10", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_busy_c11", 64'(busy_o), 64'd0);
    check("flush_hi_held", 64'(hi_o), 64'(last_hi));
    check("flush_lo_held", 64'(lo_o), 64'(last_lo));
    check("flush_dz_held", 64'(div_zero_o), 64'(last_dz));
    repeat (60) @(posedge clk); #1;
    check("flush_busy_later", 64'(busy_o), 64'd0);

`ifdef MULDIV_MADD_EN
    issue(3'd6, W'(3), W'(4), '0, W'(10), 1'b1);     wait_done();
    issue(3'd4, W'(-3), W'(5), W'(1), W'(2), 1'b1);  wait_done();
`else
    op_i = 3'd4; a_i = W'(3); b_i = W'(4); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("illegal_busy_c1", 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk); #1;
    check("illegal_busy_c4", 64'(busy_o), 64'd0);
`endif

    // Reset mid-operation aborts and clears the result registers.
    issue(3'd2, W'($urandom), W'($urandom) | W'(1), '0, '0, 1'b0);
    repeat (4) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy_o), 64'd0);
    check("rstmid_hi", 64'(hi_o), 64'd0);
    check("rstmid_lo", 64'(lo_o), 64'd0);
    last_hi = '0; last_lo = '0; last_dz = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
`ifdef MULDIV_MADD_EN
      rop = 3'($urandom_range(0, 7));
`else
      rop = 3'($urandom_range(0, 3));
`endif
      issue(rop, rnd_val(), rnd_val(), W'($urandom), W'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) wait_ready();
      else                           wait_done();
    end
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
